// File: rtl/instr_fetch_unit.sv
// LEGv8 PC register and single-outstanding instruction fetch sequencer.
// Issues one imem request per PC, holds the response until Advance.
module instr_fetch_unit #(
    parameter int              PC_W     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               resetl,
    input  logic [PC_W-1:0]    NextPC,
    input  logic               Advance,
    output logic               ImemReqValid,
    input  logic               ImemReqReady,
    output logic [PC_W-1:0]    ImemAddr,
    input  logic               ImemRspValid,
    input  logic [INSTR_W-1:0] ImemRspData,
    output logic [PC_W-1:0]    CurrentPC,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    output logic               FetchFault,
    output logic [31:0]        InstrCount
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0] state;
    logic       req_valid;
    logic       misaligned;

    assign misaligned   = NextPC[1:0] != 2'b00;
    assign ImemReqValid = req_valid;
    assign ImemAddr     = CurrentPC;

    // Request valid is a flop so it can never glitch high during reset.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state       <= S_REQ;
            req_valid   <= 1'b0;
            CurrentPC   <= RESET_PC;
            Instruction <= '0;
            InstrValid  <= 1'b0;
            FetchFault  <= 1'b0;
            InstrCount  <= '0;
        end else begin
            unique case (1'b1)
                (state == S_REQ): begin
                    if (!req_valid) begin
                        req_valid <= 1'b1;
                    end else if (ImemReqReady) begin
                        req_valid <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                (state == S_WAIT): begin
                    if (ImemRspValid) begin
                        Instruction <= ImemRspData;
                        InstrValid  <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                (state == S_HOLD): begin
                    if (Advance) begin
                        InstrValid <= 1'b0;
                        if (misaligned) begin
                            FetchFault <= 1'b1;
                            state      <= S_FAULT;
                        end else begin
                            CurrentPC  <= NextPC;
                            InstrCount <= InstrCount + 32'd1;
                            req_valid  <= 1'b1;
                            state      <= S_REQ;
                        end
                    end
                end
                default: begin
                    req_valid  <= 1'b0;
                    InstrValid <= 1'b0;
                    state      <= S_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Inputs change and outputs are sampled #1 after each rising edge.
module tb_instr_fetch_unit;

    logic        CLK;
    logic        resetl;
    logic [63:0] NextPC;
    logic        Advance;
    logic        ImemReqValid;
    logic        ImemReqReady;
    logic [63:0] ImemAddr;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic [63:0] CurrentPC;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        FetchFault;
    logic [31:0] InstrCount;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit dut (
        .CLK          (CLK),
        .resetl       (resetl),
        .NextPC       (NextPC),
        .Advance      (Advance),
        .ImemReqValid (ImemReqValid),
        .ImemReqReady (ImemReqReady),
        .ImemAddr     (ImemAddr),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .CurrentPC    (CurrentPC),
        .Instruction  (Instruction),
        .InstrValid   (InstrValid),
        .FetchFault   (FetchFault),
        .InstrCount   (InstrCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        resetl       = 1'b0;
        NextPC       = '0;
        Advance      = 1'b0;
        ImemReqReady = 1'b0;
        ImemRspValid = 1'b0;
        ImemRspData  = '0;
        #3;
        n_checks++;
        if (CurrentPC !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_pc got %h want 0", CurrentPC);
        end
        n_checks++;
        if (InstrValid !== 1'b0 || ImemReqValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got iv=%b rv=%b want 0 0",
                     InstrValid, ImemReqValid);
        end
        n_checks++;
        if (InstrCount !== 32'h0 || FetchFault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cnt got cnt=%h ff=%b want 0 0",
                     InstrCount, FetchFault);
        end
        tick();
        n_checks++;
        if (ImemReqValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_req got %b want 0", ImemReqValid);
        end
        resetl = 1'b1;
        tick();
        n_checks++;
        if (ImemReqValid !== 1'b1 || ImemAddr !== 64'h0) begin
            n_fail++;
            $display("FAIL release_req got rv=%b addr=%h want 1 0",
                     ImemReqValid, ImemAddr);
        end
    endtask

    task automatic test_fetch();
        ImemReqReady = 1'b1;
        tick();
        n_checks++;
        if (ImemReqValid !== 1'b0 || InstrValid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_wait got rv=%b iv=%b want 0 0",
                     ImemReqValid, InstrValid);
        end
        ImemRspValid = 1'b1;
        ImemRspData  = 32'h8B020020;
        tick();
        ImemRspValid = 1'b0;
        n_checks++;
        if (InstrValid !== 1'b1 || Instruction !== 32'h8B020020
            || CurrentPC !== 64'h0) begin
            n_fail++;
            $display("FAIL fetch_rsp got iv=%b ins=%h pc=%h want 1 8b020020 0",
                     InstrValid, Instruction, CurrentPC);
        end
        Advance = 1'b1;
        NextPC  = 64'h4;
        tick();
        Advance = 1'b0;
        NextPC  = 64'hF3;
        n_checks++;
        if (ImemAddr !== 64'h4 || ImemReqValid !== 1'b1
            || InstrCount !== 32'd1 || InstrValid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_adv got addr=%h rv=%b cnt=%0d iv=%b want 4 1 1 0",
                     ImemAddr, ImemReqValid, InstrCount, InstrValid);
        end
    endtask

    task automatic test_branch();
        tick();
        ImemRspValid = 1'b1;
        ImemRspData  = 32'hB4000100;
        tick();
        ImemRspValid = 1'b0;
        n_checks++;
        if (InstrValid !== 1'b1 || CurrentPC !== 64'h4
            || Instruction !== 32'hB4000100) begin
            n_fail++;
            $display("FAIL br_hold got iv=%b pc=%h ins=%h want 1 4 b4000100",
                     InstrValid, CurrentPC, Instruction);
        end
        Advance = 1'b1;
        NextPC  = 64'h24;
        tick();
        Advance = 1'b0;
        n_checks++;
        if (ImemAddr !== 64'h24 || CurrentPC !== 64'h24
            || InstrValid !== 1'b0 || InstrCount !== 32'd2) begin
            n_fail++;
            $display("FAIL br_target got addr=%h pc=%h iv=%b cnt=%0d want 24 24 0 2",
                     ImemAddr, CurrentPC, InstrValid, InstrCount);
        end
    endtask

    task automatic test_stall();
        ImemReqReady = 1'b0;
        ImemRspValid = 1'b1;
        ImemRspData  = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (ImemReqValid !== 1'b1 || ImemAddr !== 64'h24
                || InstrValid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_%0d got rv=%b addr=%h iv=%b want 1 24 0",
                         i, ImemReqValid, ImemAddr, InstrValid);
            end
        end
        ImemRspValid = 1'b0;
        ImemReqReady = 1'b1;
        tick();
        n_checks++;
        if (ImemReqValid !== 1'b0 || InstrValid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_accept got rv=%b iv=%b want 0 0",
                     ImemReqValid, InstrValid);
        end
        ImemRspValid = 1'b1;
        ImemRspData  = 32'h11111111;
        tick();
        ImemRspValid = 1'b0;
        n_checks++;
        if (InstrValid !== 1'b1 || Instruction !== 32'h11111111) begin
            n_fail++;
            $display("FAIL stall_rsp got iv=%b ins=%h want 1 11111111",
                     InstrValid, Instruction);
        end
    endtask

    task automatic test_fault();
        Advance = 1'b1;
        NextPC  = 64'h6;
        tick();
        n_checks++;
        if (FetchFault !== 1'b1 || CurrentPC !== 64'h24
            || InstrValid !== 1'b0 || ImemReqValid !== 1'b0
            || InstrCount !== 32'd2) begin
            n_fail++;
            $display("FAIL fault_enter got ff=%b pc=%h iv=%b rv=%b cnt=%0d want 1 24 0 0 2",
                     FetchFault, CurrentPC, InstrValid, ImemReqValid, InstrCount);
        end
        NextPC       = 64'h8;
        ImemRspValid = 1'b1;
        ImemReqReady = 1'b1;
        ImemRspData  = 32'h22222222;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (FetchFault !== 1'b1 || CurrentPC !== 64'h24
                || InstrValid !== 1'b0 || ImemReqValid !== 1'b0
                || Instruction !== 32'h11111111 || InstrCount !== 32'd2) begin
                n_fail++;
                $display("FAIL fault_frozen_%0d got ff=%b pc=%h iv=%b rv=%b ins=%h cnt=%0d",
                         i, FetchFault, CurrentPC, InstrValid, ImemReqValid,
                         Instruction, InstrCount);
            end
        end
        Advance      = 1'b0;
        ImemRspValid = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        resetl = 1'b0;
        #1;
        n_checks++;
        if (FetchFault !== 1'b0 || CurrentPC !== 64'h0
            || InstrCount !== 32'h0) begin
            n_fail++;
            $display("FAIL fault_clear got ff=%b pc=%h cnt=%0d want 0 0 0",
                     FetchFault, CurrentPC, InstrCount);
        end
        resetl       = 1'b1;
        ImemReqReady = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ImemReqValid !== 1'b0 || InstrValid !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_wait got rv=%b iv=%b want 0 0",
                     ImemReqValid, InstrValid);
        end
        #2;
        resetl = 1'b0;
        #1;
        n_checks++;
        if (ImemReqValid !== 1'b0 || InstrValid !== 1'b0
            || CurrentPC !== 64'h0) begin
            n_fail++;
            $display("FAIL rw_async got rv=%b iv=%b pc=%h want 0 0 0",
                     ImemReqValid, InstrValid, CurrentPC);
        end
        resetl       = 1'b1;
        ImemReqReady = 1'b0;
        ImemRspValid = 1'b1;
        ImemRspData  = 32'hCAFEF00D;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (ImemReqValid !== 1'b1 || ImemAddr !== 64'h0
                || InstrValid !== 1'b0 || Instruction !== 32'h0) begin
                n_fail++;
                $display("FAIL rw_drop_%0d got rv=%b addr=%h iv=%b ins=%h want 1 0 0 0",
                         i, ImemReqValid, ImemAddr, InstrValid, Instruction);
            end
        end
        ImemRspValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_branch();
        test_stall();
        test_fault();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
